// File: rtl/cw_enc_pkg.sv
// Shared constants, state encoding and a width helper for the constant-weight
// encoder. The *_DEF values are the default parameter values of the encoder.
package cw_enc_pkg;

   localparam int CW_W_DEF   = 16;     // width of each emitted distance word
   localparam int CW_T_DEF   = 9;      // number of distance words per codeword
   localparam int D_BITS_DEF = 11;     // remainder field width, chunk = 2**D_BITS
   localparam int N_LEN_DEF  = 16384;  // codeword length, must be < 2**CW_W

   // Encoder control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UNARY  = 2'd1,
      BINARY = 2'd2,
      EMIT   = 2'd3
   } state_t;

   // Bits needed to hold the values 0 .. value-1, never less than one bit.
   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/cw_rem_tracker.sv
// Tracks the room left in the codeword (rem) and the index of the word being
// built (i). From them it derives dmax, the largest gap that still leaves one
// position for every remaining nonzero, plus the unary-run limit and the
// last-word flag the encoder FSM steers on.
module cw_rem_tracker
   import cw_enc_pkg::*;
#(
   parameter int CW_W   = CW_W_DEF,
   parameter int CW_T   = CW_T_DEF,
   parameter int D_BITS = D_BITS_DEF,
   parameter int N_LEN  = N_LEN_DEF
)(
   input  logic            clk,
   input  logic            rst_b,        // synchronous, active-high
   input  logic            i_init,       // load a fresh codeword
   input  logic            i_step,       // a word of width i_g was emitted
   input  logic [CW_W-1:0] i_g,          // emitted (already clamped) gap
   input  logic [CW_W-1:0] i_delta,      // unary part accumulated so far
   output logic [CW_W-1:0] o_dmax,       // largest legal gap for word i
   output logic            o_unary_lim,  // one more chunk would exceed dmax
   output logic            o_last        // word i is the final one
);

   localparam int I_W = clog2_min1(CW_T);

   // One spare bit so delta + chunk cannot wrap before the compare.
   localparam logic [CW_W:0] CHUNK_EXT = (CW_W + 1)'(2 ** D_BITS);

   logic [CW_W-1:0] r_rem;
   logic [I_W-1:0]  r_i;

   logic [CW_W-1:0] w_left;
   logic [CW_W:0]   w_reach;

   // Room and word index: loaded at start, consumed by every emitted word.
   // NOTE: sequential state is written only with <= so every register in the
   // design samples the values from before the edge, whatever the block order.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_rem <= '0;
         r_i   <= '0;
      end else if (i_init) begin
         r_rem <= CW_W'(N_LEN);
         r_i   <= '0;
      end else if (i_step) begin
         // The gap itself plus the nonzero position that terminates it.
         r_rem <= r_rem - i_g - CW_W'(1);
         r_i   <= r_i + I_W'(1);
      end
   end

   // Positions still reserved for the ones that follow word i.
   assign w_left = CW_W'(CW_T) - CW_W'(r_i);

   // Never negative while encoding: every gap is clamped to dmax.
   assign o_dmax = r_rem - w_left;

   assign w_reach     = {1'b0, i_delta} + CHUNK_EXT;
   assign o_unary_lim = (w_reach > {1'b0, o_dmax});
   assign o_last      = (r_i == I_W'(CW_T - 1));

endmodule

// File: rtl/cw_encoder_top.sv
// Constant-weight encoder. Turns a serial message into CW_T gap words: each gap
// is a unary count of 2**D_BITS chunks (1 = another chunk, 0 = stop) followed
// by a D_BITS-bit remainder, MSB first. A unary run is cut short without
// reading its terminating 0 when another chunk could not fit, and a gap that
// still exceeds the room left is clamped and flagged on cw_ofl.
module cw_encoder_top
   import cw_enc_pkg::*;
#(
   parameter int CW_W   = CW_W_DEF,
   parameter int CW_T   = CW_T_DEF,
   parameter int D_BITS = D_BITS_DEF,
   parameter int N_LEN  = N_LEN_DEF
)(
   input  logic            clk,
   input  logic            rst_b,     // synchronous, active-high
   input  logic            start,
   input  logic            bin_msg,
   input  logic            bin_vld,
   output logic            bin_rdy,
   output logic [CW_W-1:0] cw_word,
   output logic            cw_vld,
   output logic            cw_done,
   output logic            cw_ofl
);

   localparam int              J_W   = clog2_min1(D_BITS);
   localparam logic [CW_W-1:0] CHUNK = CW_W'(2 ** D_BITS);

   state_t r_state;
   state_t w_state_nxt;

   logic [CW_W-1:0]   r_delta;     // unary part of the current gap
   logic [D_BITS-1:0] r_u;         // remainder bits shifted in so far
   logic [J_W-1:0]    r_j;         // remainder bits still to read, minus one

   logic [CW_W-1:0]   r_cw_word;
   logic              r_cw_vld;
   logic              r_cw_done;
   logic              r_cw_ofl;

   logic              w_rdy;
   logic              w_take;      // a message bit is consumed this cycle
   logic              w_init;      // accepted start
   logic              w_step;      // EMIT cycle: the gap is final
   logic [CW_W-1:0]   w_dmax;
   logic              w_unary_lim;
   logic              w_last;
   logic [CW_W-1:0]   w_g_raw;
   logic              w_sat;
   logic [CW_W-1:0]   w_g;

   cw_rem_tracker #(
      .CW_W   (CW_W),
      .CW_T   (CW_T),
      .D_BITS (D_BITS),
      .N_LEN  (N_LEN)
   ) u_rem (
      .clk         (clk),
      .rst_b       (rst_b),
      .i_init      (w_init),
      .i_step      (w_step),
      .i_g         (w_g),
      .i_delta     (r_delta),
      .o_dmax      (w_dmax),
      .o_unary_lim (w_unary_lim),
      .o_last      (w_last)
   );

   // Gap candidate and its clamp to the room left for this word. delta never
   // exceeds dmax and u stays below one chunk, so the sum cannot wrap.
   assign w_g_raw = r_delta + CW_W'(r_u);
   assign w_sat   = (w_g_raw > w_dmax);
   assign w_g     = w_sat ? w_dmax : w_g_raw;

   // State register.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake; a truncating UNARY cycle keeps bin_rdy low so
   // no bit is consumed while the run is cut short.
   // NOTE: every signal written here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_rdy       = 1'b0;
      w_init      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_init      = 1'b1;
               w_state_nxt = UNARY;
            end
         end
         UNARY: begin
            if (w_unary_lim) begin
               w_state_nxt = BINARY;
            end else begin
               w_rdy = 1'b1;
               if (bin_vld && !bin_msg) begin
                  w_state_nxt = BINARY;
               end
            end
         end
         BINARY: begin
            w_rdy = 1'b1;
            if (bin_vld && (r_j == '0)) begin
               w_state_nxt = EMIT;
            end
         end
         EMIT: begin
            w_step      = 1'b1;
            w_state_nxt = w_last ? IDLE : UNARY;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_take = w_rdy & bin_vld;

   // Gap accumulators: chunk count in UNARY, remainder shift-in in BINARY.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_delta <= '0;
         r_u     <= '0;
         r_j     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_delta <= '0;
               end
            end
            UNARY: begin
               if (w_unary_lim || (w_take && !bin_msg)) begin
                  r_u <= '0;
                  r_j <= J_W'(D_BITS - 1);
               end else if (w_take) begin
                  r_delta <= r_delta + CHUNK;
               end
            end
            BINARY: begin
               if (w_take) begin
                  r_u <= {r_u[D_BITS-2:0], bin_msg};
                  r_j <= r_j - J_W'(1);
               end
            end
            EMIT: begin
               r_delta <= '0;
            end
            default: begin
               r_delta <= '0;
            end
         endcase
      end
   end

   // Output registers: one-cycle word/done pulses, held word, sticky overflow.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_cw_word <= '0;
         r_cw_vld  <= 1'b0;
         r_cw_done <= 1'b0;
         r_cw_ofl  <= 1'b0;
      end else begin
         r_cw_vld  <= w_step;
         r_cw_done <= w_step & w_last;
         if (w_step) begin
            r_cw_word <= w_g;
         end
         if (w_init) begin
            r_cw_ofl <= 1'b0;
         end else if (w_step && w_sat) begin
            r_cw_ofl <= 1'b1;
         end
      end
   end

   assign bin_rdy = w_rdy;
   assign cw_word = r_cw_word;
   assign cw_vld  = r_cw_vld;
   assign cw_done = r_cw_done;
   assign cw_ofl  = r_cw_ofl;

endmodule

// File: tb/tb_cw_encoder_top.sv
// Bench for cw_encoder_top. A message-level model turns the bit stream fed to
// the DUT into the words, done flags and overflow flags it must produce; one
// compare process checks every cw_vld pulse against that queue. Literal
// values pin the model on the directed cases.
module tb_cw_encoder_top;
   import cw_enc_pkg::*;

   localparam int W     = CW_W_DEF;
   localparam int T     = CW_T_DEF;
   localparam int D     = D_BITS_DEF;
   localparam int N     = N_LEN_DEF;
   localparam int CHUNK = 1 << D;

   typedef struct {
      int word;
      bit done;
      bit ofl;
   } exp_t;

   logic         clk     = 1'b0;
   logic         rst_b   = 1'b1;
   logic         start   = 1'b0;
   logic         bin_msg = 1'b0;
   logic         bin_vld = 1'b0;
   logic         bin_rdy;
   logic [W-1:0] cw_word;
   logic         cw_vld;
   logic         cw_done;
   logic         cw_ofl;

   int   n_vec     = 0;
   int   n_err     = 0;
   int   cyc       = 0;
   int   n_done    = 0;
   int   last_cons = 0;
   int   vld_cyc   = 0;
   exp_t exp_q[$];
   exp_t cmp_e;
   int   got_q[$];
   bit   msg_q[$];

   int   w3[T] = '{2058, 6766, 1261, 10504, 5711, 13502, 5971, 5852, 13249};
   int   w4[T] = '{16000, 0, 0, 0, 0, 0, 0, 0, 0};

   cw_encoder_top dut (
      .clk     (clk),
      .rst_b   (rst_b),
      .start   (start),
      .bin_msg (bin_msg),
      .bin_vld (bin_vld),
      .bin_rdy (bin_rdy),
      .cw_word (cw_word),
      .cw_vld  (cw_vld),
      .cw_done (cw_done),
      .cw_ofl  (cw_ofl)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Message-level model: read the bit stream the way the code is defined and
   // queue the words that must appear. Stops at the first incomplete word.
   function automatic void model(input bit b[$]);
      int rem, dmax, delta, u, g, k;
      bit ofl, cut;
      rem = N;
      ofl = 1'b0;
      k   = 0;
      exp_q.delete();
      for (int i = 0; i < T; i++) begin
         dmax  = rem - (T - i);
         delta = 0;
         u     = 0;
         cut   = 1'b0;
         while (!cut && (delta + CHUNK <= dmax)) begin
            if (k >= b.size()) return;
            if (b[k]) delta += CHUNK;
            else      cut = 1'b1;
            k++;
         end
         for (int j = 0; j < D; j++) begin
            if (k >= b.size()) return;
            u = 2 * u + int'(b[k]);
            k++;
         end
         g = delta + u;
         if (g > dmax) begin
            g   = dmax;
            ofl = 1'b1;
         end
         exp_q.push_back('{g, (i == T - 1), ofl});
         rem -= g + 1;
      end
   endfunction

   // Inverse of the code: the bits a message must carry to yield the given
   // gaps. Each target is bounded by the room left, as any decoded word is.
   function automatic void gen(input int w[T]);
      int rem, dmax, tgt, delta, u;
      rem = N;
      msg_q.delete();
      for (int i = 0; i < T; i++) begin
         dmax  = rem - (T - i);
         tgt   = (w[i] > dmax) ? dmax : w[i];
         delta = 0;
         while (delta + CHUNK <= tgt) begin
            msg_q.push_back(1'b1);
            delta += CHUNK;
         end
         if (delta + CHUNK <= dmax) msg_q.push_back(1'b0);
         u = tgt - delta;
         for (int j = D - 1; j >= 0; j--) msg_q.push_back(1'(u >> j));
         rem -= tgt + 1;
      end
   endfunction

   // Compare process: every word pulse against the model queue.
   always @(negedge clk) begin
      if (cw_done) check("done_has_vld", cw_vld, 1);
      if (cw_vld) begin
         vld_cyc = cyc;
         got_q.push_back(int'(cw_word));
         check("word_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("cw_word", cw_word, cmp_e.word);
            check("cw_done", cw_done, cmp_e.done);
            check("cw_ofl", cw_ofl, cmp_e.ofl);
         end
         if (cw_done) n_done++;
      end
   end

   // Start a message and feed msg_q under the bin_vld/bin_rdy handshake.
   task automatic run_msg(input bit rnd, input bit noise, input bit expect_done);
      bit q[$];
      int d0;
      int budget;
      q  = msg_q;
      d0 = n_done;
      got_q.delete();
      @(negedge clk);
      start   = 1'b1;
      bin_vld = 1'b0;
      @(negedge clk);
      start  = 1'b0;
      budget = 4000;
      while (q.size() > 0 && budget > 0) begin
         bin_msg = q[0];
         bin_vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start   = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (bin_rdy && bin_vld) begin
            void'(q.pop_front());
            last_cons = cyc + 1;
         end
         @(negedge clk);
         budget--;
      end
      start   = 1'b0;
      bin_vld = 1'b0;
      check("bits_left_unconsumed", q.size(), 0);
      if (expect_done) begin
         for (int k = 0; k < 16 && n_done == d0; k++) @(negedge clk);
         check("done_pulses", n_done - d0, 1);
      end else begin
         repeat (6) @(negedge clk);
      end
      check("words_outstanding", exp_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_bin_rdy"}, bin_rdy, 0);
      check({tag, "_cw_vld"}, cw_vld, 0);
      check({tag, "_cw_done"}, cw_done, 0);
      check({tag, "_cw_ofl"}, cw_ofl, 0);
      check({tag, "_cw_word"}, cw_word, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish within time limit");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Power-on reset.
      repeat (3) @(negedge clk);
      check_zero_outputs("por");
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_rdy", bin_rdy, 0);

      // Remainder overflow: 7 chunks then u = 2047 overshoots dmax 16375;
      // every later word has no room and reads an all-zero remainder.
      msg_q.delete();
      repeat (18) msg_q.push_back(1'b1);
      repeat ((T - 1) * D) msg_q.push_back(1'b0);
      model(msg_q);
      run_msg(1'b0, 1'b0, 1'b1);
      check("ofl_word0", got_q.size() > 0 ? got_q[0] : -1, 16375);
      check("ofl_word8", got_q.size() > 8 ? got_q[8] : -1, 0);
      repeat (3) @(negedge clk);
      check("ofl_sticky", cw_ofl, 1);

      // Single word 2058 = one chunk + 10; start also clears the overflow.
      msg_q = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
      model(msg_q);
      run_msg(1'b0, 1'b0, 1'b0);
      check("w2058_word", got_q.size() > 0 ? got_q[0] : -1, 2058);
      check("w2058_count", got_q.size(), 1);
      check("w2058_rem", dut.u_rem.r_rem, 14325);
      check("w2058_latency", vld_cyc - last_cons, 1);
      check("ofl_cleared", cw_ofl, 0);

      // Reset held 3 cycles in the middle of the next word's remainder.
      bin_vld = 1'b1;
      bin_msg = 1'b0;
      @(negedge clk);
      bin_msg = 1'b1;
      @(negedge clk);
      bin_msg = 1'b0;
      @(negedge clk);
      check("pre_reset_rdy", bin_rdy, 1);
      rst_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_zero_outputs("rst");
      end
      rst_b   = 1'b0;
      bin_vld = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_idle", bin_rdy, 0);
      end

      // Full message, steady bin_vld.
      gen(w3);
      check("full_bits", msg_q.size(), 109);
      model(msg_q);
      run_msg(1'b0, 1'b0, 1'b1);
      check("full_count", got_q.size(), T);
      check("full_word0", got_q.size() > 0 ? got_q[0] : -1, 2058);
      check("full_word3", got_q.size() > 3 ? got_q[3] : -1, 6290);
      check("full_ofl", cw_ofl, 0);

      // Unary truncation: 7 chunks fill the room, no terminating 0 is read.
      gen(w4);
      check("trunc_bits", msg_q.size(), 106);
      model(msg_q);
      run_msg(1'b0, 1'b0, 1'b1);
      check("trunc_word0", got_q.size() > 0 ? got_q[0] : -1, 16000);

      // Full message again with a stalling source and stray start pulses.
      gen(w3);
      model(msg_q);
      run_msg(1'b1, 1'b1, 1'b1);
      check("stall_count", got_q.size(), T);
      check("stall_word1", got_q.size() > 1 ? got_q[1] : -1, 6766);
      check("stall_word2", got_q.size() > 2 ? got_q[2] : -1, 1261);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
